// File: rtl/digital_input_deserializer_n_if.sv
// rtl/digital_input_deserializer_n_if.sv - SPI-slot and shift-chain bundle for the digital-input deserializer
// master drives main_state/channel/serial_in and observes the committed word; slave is the deserializer.
interface digital_input_deserializer_n_if #(
    parameter int BITS   = 16,
    parameter int CHAINS = 2
) ();
    logic [31:0]            main_state;
    logic [5:0]             channel;
    logic [CHAINS-1:0]      serial_in;
    logic                   serial_CLK;
    logic                   serial_LOAD;
    logic [CHAINS*BITS-1:0] TTL_parallel;
    logic [CHAINS*BITS-1:0] TTL_rise;
    logic [CHAINS*BITS-1:0] TTL_fall;
    logic                   TTL_valid;
    logic                   frame_error;

    modport master (
        output main_state, channel, serial_in,
        input  serial_CLK, serial_LOAD, TTL_parallel, TTL_rise, TTL_fall, TTL_valid, frame_error
    );

    modport slave (
        input  main_state, channel, serial_in,
        output serial_CLK, serial_LOAD, TTL_parallel, TTL_rise, TTL_fall, TTL_valid, frame_error
    );
endinterface

// File: rtl/digital_input_deserializer_n.sv
// rtl/digital_input_deserializer_n.sv - LOAD/CLK driver and per-frame parallel capture of CHAINS shift chains
// Optional two-frame debounce when DIN_DEBOUNCE_EN is defined.
module digital_input_deserializer_n #(
    parameter int          BITS       = 16,
    parameter int          CHAINS     = 2,
    parameter logic [31:0] ms_wait    = 32'd99,
    parameter logic [31:0] ms_clk1_a  = 32'd100,
    parameter logic [31:0] ms_clk11_a = 32'd140
) (
    input logic                        dataclk,
    input logic                        reset,
    digital_input_deserializer_n_if.slave bus
);
    localparam int         W      = CHAINS * BITS;
    localparam logic [5:0] BITS_L = 6'(BITS);
    localparam logic [5:0] TOP_L  = 6'(BITS - 1);

    logic         load_q, load_d;
    logic         clk_q, clk_d;
    logic [W-1:0] shadow_q, shadow_d;
    logic [5:0]   cnt_q, cnt_d;
    logic [W-1:0] par_q, par_d;
    logic [W-1:0] rise_q, rise_d;
    logic [W-1:0] fall_q, fall_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;
    logic [W-1:0] cand;
    logic [5:0]   bit_idx;
    logic         sample_slot;
    logic         commit_slot;
`ifdef DIN_DEBOUNCE_EN
    logic [W-1:0] prev_q, prev_d;
`endif

    assign sample_slot = (bus.main_state == ms_clk11_a) && (bus.channel < BITS_L);
    assign commit_slot = (bus.main_state == ms_clk11_a) && (bus.channel == BITS_L);
    // The first bit shifted out of a chain is its MSB.
    assign bit_idx     = TOP_L - bus.channel;

`ifdef DIN_DEBOUNCE_EN
    // A bit follows the shadow only when two consecutive frames agree.
    assign cand = (shadow_q & ~(shadow_q ^ prev_q)) | (par_q & (shadow_q ^ prev_q));
`else
    assign cand = shadow_q;
`endif

    always_comb begin
        load_d   = load_q;
        clk_d    = clk_q;
        shadow_d = shadow_q;
        cnt_d    = cnt_q;
        par_d    = par_q;
        rise_d   = rise_q;
        fall_d   = fall_q;
        valid_d  = 1'b0;
        err_d    = err_q;
`ifdef DIN_DEBOUNCE_EN
        prev_d   = prev_q;
`endif
        if (bus.main_state == ms_wait || bus.main_state == ms_clk11_a) begin
            load_d = 1'b1;
            clk_d  = 1'b0;
        end else if (bus.main_state == ms_clk1_a) begin
            if (bus.channel == 6'd0) begin
                load_d = 1'b0;
                clk_d  = 1'b0;
            end else if (bus.channel < BITS_L) begin
                load_d = 1'b1;
                clk_d  = 1'b1;
            end else begin
                load_d = 1'b1;
                clk_d  = 1'b0;
            end
        end

        if (sample_slot) begin
            for (int c = 0; c < CHAINS; c++) begin
                for (int b = 0; b < BITS; b++) begin
                    if (6'(b) == bit_idx) begin
                        shadow_d[c*BITS + b] = bus.serial_in[c];
                    end
                end
            end
            if (bus.channel == 6'd0) begin
                cnt_d = 6'd1;
            end else if (cnt_q != 6'd63) begin
                cnt_d = cnt_q + 6'd1;
            end
        end

        if (commit_slot) begin
            cnt_d = 6'd0;
            if (cnt_q == BITS_L) begin
                rise_d  = cand & ~par_q;
                fall_d  = ~cand & par_q;
                par_d   = cand;
                valid_d = 1'b1;
`ifdef DIN_DEBOUNCE_EN
                prev_d  = shadow_q;
`endif
            end else begin
                err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge dataclk or posedge reset) begin
        if (reset) begin
            load_q   <= 1'b1;
            clk_q    <= 1'b0;
            shadow_q <= '0;
            cnt_q    <= '0;
            par_q    <= '0;
            rise_q   <= '0;
            fall_q   <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
`ifdef DIN_DEBOUNCE_EN
            prev_q   <= '0;
`endif
        end else begin
            load_q   <= load_d;
            clk_q    <= clk_d;
            shadow_q <= shadow_d;
            cnt_q    <= cnt_d;
            par_q    <= par_d;
            rise_q   <= rise_d;
            fall_q   <= fall_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
`ifdef DIN_DEBOUNCE_EN
            prev_q   <= prev_d;
`endif
        end
    end

    assign bus.serial_LOAD  = load_q;
    assign bus.serial_CLK   = clk_q;
    assign bus.TTL_parallel = par_q;
    assign bus.TTL_rise     = rise_q;
    assign bus.TTL_fall     = fall_q;
    assign bus.TTL_valid    = valid_q;
    assign bus.frame_error  = err_q;
endmodule

// File: tb/tb_digital_input_deserializer_n.sv
// tb/tb_digital_input_deserializer_n.sv - directed scoreboard bench for digital_input_deserializer_n
// Debounce expectations follow DIN_DEBOUNCE_EN when the bench is built with it.
module tb_digital_input_deserializer_n;
    localparam int          BITS     = 16;
    localparam int          CHAINS   = 2;
    localparam int          W        = CHAINS * BITS;
    localparam logic [31:0] MS_WAIT  = 32'd99;
    localparam logic [31:0] MS_CLK1  = 32'd100;
    localparam logic [31:0] MS_MID   = 32'd120;
    localparam logic [31:0] MS_CLK11 = 32'd140;

    typedef struct packed {
        logic [W-1:0] par;
        logic [W-1:0] rise;
        logic [W-1:0] fall;
    } exp_t;

    logic dataclk = 1'b0;
    logic reset   = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    exp_t sbq[$];

    logic [W-1:0] m_sh, m_prev, m_par, m_rise, m_fall;
    logic [5:0]   m_cnt;
    logic         m_err;

    digital_input_deserializer_n_if #(.BITS(BITS), .CHAINS(CHAINS)) bus ();

    digital_input_deserializer_n #(
        .BITS(BITS), .CHAINS(CHAINS),
        .ms_wait(MS_WAIT), .ms_clk1_a(MS_CLK1), .ms_clk11_a(MS_CLK11)
    ) dut (
        .dataclk(dataclk),
        .reset  (reset),
        .bus    (bus)
    );

    always #5 dataclk = ~dataclk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_sh = '0; m_prev = '0; m_par = '0; m_rise = '0; m_fall = '0;
        m_cnt = '0; m_err = 1'b0;
        sbq.delete();
    endtask

    task automatic step(input logic [31:0] st, input int ch, input logic [CHAINS-1:0] si);
        bus.main_state = st;
        bus.channel    = 6'(ch);
        bus.serial_in  = si;
        @(posedge dataclk);
        #1;
    endtask

    task automatic slot(input logic [W-1:0] word, input int k, input bit do_sample);
        logic [CHAINS-1:0] si;
        logic [W-1:0]      cand;
        bit                exp_v;
        exp_t              e;
        si    = '0;
        exp_v = 1'b0;
        step(MS_CLK1, k, '0);
        step(MS_MID, k, '0);
        if (do_sample) begin
            if (k < BITS) begin
                for (int c = 0; c < CHAINS; c++) begin
                    si[c] = word[c*BITS + BITS-1-k];
                    m_sh[c*BITS + BITS-1-k] = si[c];
                end
                if (k == 0) m_cnt = 6'd1;
                else if (m_cnt != 6'd63) m_cnt = m_cnt + 6'd1;
            end else if (k == BITS) begin
                if (m_cnt == 6'(BITS)) begin
`ifdef DIN_DEBOUNCE_EN
                    cand = (m_sh & ~(m_sh ^ m_prev)) | (m_par & (m_sh ^ m_prev));
`else
                    cand = m_sh;
`endif
                    m_rise = cand & ~m_par;
                    m_fall = ~cand & m_par;
                    m_par  = cand;
                    m_prev = m_sh;
                    exp_v  = 1'b1;
                    sbq.push_back('{par: m_par, rise: m_rise, fall: m_fall});
                end else begin
                    m_err = 1'b1;
                end
                m_cnt = 6'd0;
            end
            step(MS_CLK11, k, si);
            if (k == BITS) begin
                chk("commit_valid", 64'(bus.TTL_valid), 64'(exp_v));
                if (bus.TTL_valid === 1'b1 && sbq.size() > 0) begin
                    e = sbq.pop_front();
                    chk("sb_parallel", 64'(bus.TTL_parallel), 64'(e.par));
                    chk("sb_rise", 64'(bus.TTL_rise), 64'(e.rise));
                    chk("sb_fall", 64'(bus.TTL_fall), 64'(e.fall));
                end else begin
                    sbq.delete();
                    chk("hold_parallel", 64'(bus.TTL_parallel), 64'(m_par));
                end
                chk("frame_error", 64'(bus.frame_error), 64'(m_err));
            end
        end
    endtask

    task automatic frame(input logic [W-1:0] word, input int first, input int last, input int skip);
        for (int k = first; k <= last; k++) slot(word, k, k != skip);
        step(MS_WAIT, 0, '0);
        chk("valid_one_cycle", 64'(bus.TTL_valid), 64'd0);
    endtask

    initial begin
        model_reset();
        bus.main_state = MS_WAIT;
        bus.channel    = '0;
        bus.serial_in  = '0;
        repeat (3) @(posedge dataclk);
        #1;
        chk("rst_load", 64'(bus.serial_LOAD), 64'd1);
        chk("rst_clk", 64'(bus.serial_CLK), 64'd0);
        chk("rst_parallel", 64'(bus.TTL_parallel), 64'd0);
        chk("rst_valid", 64'(bus.TTL_valid), 64'd0);
        chk("rst_error", 64'(bus.frame_error), 64'd0);
        reset = 1'b0;

        frame(32'h0001_A5C3, 0, BITS, -1);
`ifndef DIN_DEBOUNCE_EN
        chk("f1_parallel", 64'(bus.TTL_parallel), 64'h0001_A5C3);
        chk("f1_rise", 64'(bus.TTL_rise), 64'h0001_A5C3);
        chk("f1_fall", 64'(bus.TTL_fall), 64'd0);
`endif

        step(MS_CLK1, 0, '0);
        chk("line_ch0_load", 64'(bus.serial_LOAD), 64'd0);
        chk("line_ch0_clk", 64'(bus.serial_CLK), 64'd0);
        step(MS_CLK1, 5, '0);
        chk("line_ch5_load", 64'(bus.serial_LOAD), 64'd1);
        chk("line_ch5_clk", 64'(bus.serial_CLK), 64'd1);
        step(MS_MID, 5, '0);
        chk("line_hold_clk", 64'(bus.serial_CLK), 64'd1);
        step(MS_CLK1, 20, '0);
        chk("line_ch20_load", 64'(bus.serial_LOAD), 64'd1);
        chk("line_ch20_clk", 64'(bus.serial_CLK), 64'd0);
        step(MS_WAIT, 0, '0);
        chk("line_wait_load", 64'(bus.serial_LOAD), 64'd1);
        chk("line_wait_clk", 64'(bus.serial_CLK), 64'd0);

        frame(32'h0001_A5C2, 0, BITS, -1);
`ifndef DIN_DEBOUNCE_EN
        chk("f2_fall_bit0", 64'(bus.TTL_fall[0]), 64'd1);
        chk("f2_rise", 64'(bus.TTL_rise), 64'd0);
        chk("f2_low_word", 64'(bus.TTL_parallel[15:0]), 64'hA5C2);
`endif

        frame(32'hFFFF_0000, 0, BITS, 7);
        chk("skip_error_set", 64'(bus.frame_error), 64'd1);
        frame(32'h0001_A5C2, 0, BITS, -1);
        frame(32'h0003_1234, 0, BITS, -1);
        chk("error_sticky", 64'(bus.frame_error), 64'd1);

`ifdef DIN_DEBOUNCE_EN
        frame(32'h0000_0000, 0, BITS, -1);
        frame(32'h0000_0000, 0, BITS, -1);
        chk("db_base", 64'(bus.TTL_parallel), 64'd0);
        frame(32'h0000_0001, 0, BITS, -1);
        chk("db_glitch_blocked", 64'(bus.TTL_parallel), 64'd0);
        frame(32'h0000_0000, 0, BITS, -1);
        chk("db_back", 64'(bus.TTL_parallel), 64'd0);
        frame(32'h0000_0001, 0, BITS, -1);
        chk("db_first_hold", 64'(bus.TTL_parallel), 64'd0);
        frame(32'h0000_0001, 0, BITS, -1);
        chk("db_second_hold", 64'(bus.TTL_parallel), 64'd1);
        chk("db_rise_bit0", 64'(bus.TTL_rise), 64'd1);
`else
        frame(32'h0000_0001, 0, BITS, -1);
        frame(32'h0000_0000, 0, BITS, -1);
`endif

        frame(32'h5A5A_0F0F, 0, 9, -1);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("arst_load", 64'(bus.serial_LOAD), 64'd1);
        chk("arst_clk", 64'(bus.serial_CLK), 64'd0);
        chk("arst_parallel", 64'(bus.TTL_parallel), 64'd0);
        chk("arst_rise", 64'(bus.TTL_rise), 64'd0);
        chk("arst_fall", 64'(bus.TTL_fall), 64'd0);
        chk("arst_error", 64'(bus.frame_error), 64'd0);
        @(posedge dataclk);
        #1;
        reset = 1'b0;
        frame(32'h5A5A_0F0F, 10, BITS, -1);
        chk("partial_error", 64'(bus.frame_error), 64'd1);
        chk("partial_parallel", 64'(bus.TTL_parallel), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
